mem_wb_stage: RTL
=================

# mem_wb_stage

Memory/write-back pipeline stage of the MIPS core, directly downstream of the data memory.
- Registers the memory read word, the ALU result, the link address and the write-back control on each enabled rising edge.
- Applies load-width sign or zero extension and selects the write-back value.
- Presents the registered destination and data to the register file and the forwarding unit.
- Maintains a retired-instruction counter for the debug unit.

## Interface
Parameters:
- BITS_SIZE, 32, datapath width
- BITS_REG, 5, register index width
- BITS_EXTENSION, 2, load-width select width

Ports:
- i_clk  in  1  core clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_step  in  1  stage advance enable (debug stepping); state holds when low
- i_flush  in  1  load a bubble instead of the incoming instruction
- i_valid  in  1  incoming slot holds a real instruction
- i_mem_data  in  BITS_SIZE  read word from data memory (0 when no read)
- i_alu_result  in  BITS_SIZE  EX/MEM ALU result
- i_pc_link  in  BITS_SIZE  return address for JAL/JALR
- i_rd  in  BITS_REG  destination register
- i_reg_write  in  1  instruction writes the register file
- i_mem_to_reg  in  1  write-back value comes from memory
- i_link  in  1  write-back value is i_pc_link
- i_load_ext  in  BITS_EXTENSION  00 word, 01 byte, 10 half, 11 word
- i_load_unsigned  in  1  zero-extend instead of sign-extend (LBU/LHU)
- i_halt  in  1  incoming instruction is HALT
- o_wb_data  out  BITS_SIZE  registered write-back value (also the forwarding value)
- o_wb_rd  out  BITS_REG  registered destination
- o_wb_reg_write  out  1  registered write enable
- o_retired_count  out  BITS_SIZE  number of retired valid instructions
- o_halt  out  1  sticky halt flag

## Operation
- Extension is combinational on the inputs, then captured:
  - byte: bits [7:0], upper bits filled with bit 7, or 0 when unsigned
  - half: bits [15:0], upper bits filled with bit 15, or 0 when unsigned
  - word (00 or 11): passed unmodified
- Write-back select priority: i_link, then i_mem_to_reg (extended data), then i_alu_result.
- The destination is register 0, or the write is suppressed by i_valid=0 → o_wb_reg_write captured as 0.
- Edge-update priority: reset > halted > flush > step > hold.
  - flush & step → bubble: o_wb_data=0, o_wb_rd=0, o_wb_reg_write=0; counter unchanged.
  - flush without step → hold; the flush is not remembered.
  - step & !flush → capture all fields; counter +1 when i_valid.
- o_retired_count wraps from 2^BITS_SIZE-1 to 0.

## Timing
- Latency is 1 cycle: inputs presented before rising edge N with i_step=1 appear on the outputs after edge N.
- All outputs are registered; no combinational input-to-output path.
- The data memory writes on the falling edge and reads combinationally. i_mem_data must be stable by the rising edge; this block performs no extra buffering.
- Reset value of every output is 0 (o_wb_data, o_wb_rd, o_wb_reg_write, o_retired_count, o_halt). Reset asserted mid-run clears state immediately, independent of i_clk.

## Configuration
- Macro: MEM_WB_HALT_DETECT_EN.
- Defined:
  - A step with i_valid=1, i_halt=1 and !flush captures the HALT. That step counts as retired.
  - o_halt is set and stays 1 until reset.
  - While o_halt=1, all registers hold regardless of i_step and i_flush.
- Undefined: i_halt is ignored, o_halt is tied 0, and no hold-on-halt logic exists.

## Test plan
- Reset: hold i_reset=0 with random inputs toggling → all outputs 0; release → still 0 until the first step.
- Loads:
  - i_mem_data=0x000080F0, byte signed → o_wb_data=0xFFFFFFF0
  - byte unsigned → 0x000000F0
  - half signed → 0xFFFF80F0
  - half unsigned → 0x000080F0
  - i_load_ext=11 → 0x000080F0
- Select and r0:
  - i_link=1, i_pc_link=0x40, i_mem_to_reg=1 → o_wb_data=0x40
  - i_rd=0, i_reg_write=1 → o_wb_reg_write=0
- Step and flush:
  - i_step=0 for 3 cycles with changing inputs → outputs hold
  - flush & step → bubble with count unchanged
  - flush without step → hold
- Counter: preload via 0xFFFFFFFF valid steps (or force) → next valid step gives o_retired_count=0; an invalid step leaves it unchanged.
- Halt (macro defined): valid HALT step → o_halt=1 and count+1; further steps with new data → outputs frozen; reset → o_halt=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extension, write-back select and retired-instruction counter.
// Optional HALT capture and freeze is enabled by defining MEM_WB_HALT_DETECT_EN.
module mem_wb_stage #(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_REG       = 5,
  parameter int BITS_EXTENSION = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_step,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic [BITS_SIZE-1:0]      i_mem_data,
  input  logic [BITS_SIZE-1:0]      i_alu_result,
  input  logic [BITS_SIZE-1:0]      i_pc_link,
  input  logic [BITS_REG-1:0]       i_rd,
  input  logic                      i_reg_write,
  input  logic                      i_mem_to_reg,
  input  logic                      i_link,
  input  logic [BITS_EXTENSION-1:0] i_load_ext,
  input  logic                      i_load_unsigned,
  input  logic                      i_halt,
  output logic [BITS_SIZE-1:0]      o_wb_data,
  output logic [BITS_REG-1:0]       o_wb_rd,
  output logic                      o_wb_reg_write,
  output logic [BITS_SIZE-1:0]      o_retired_count,
  output logic                      o_halt
);

  localparam logic [BITS_EXTENSION-1:0] EXT_BYTE = BITS_EXTENSION'(1);
  localparam logic [BITS_EXTENSION-1:0] EXT_HALF = BITS_EXTENSION'(2);

  logic [BITS_SIZE-1:0] ext_data;
  logic [BITS_SIZE-1:0] wb_value;

  logic [BITS_SIZE-1:0] wb_data_q, wb_data_d;
  logic [BITS_REG-1:0]  wb_rd_q, wb_rd_d;
  logic                 wb_reg_write_q, wb_reg_write_d;
  logic [BITS_SIZE-1:0] retired_q, retired_d;
  logic                 halted;

  // Fill the whole word with the sign (or zero), then overlay the loaded low bits.
  always_comb begin
    ext_data = i_mem_data;
    case (i_load_ext)
      EXT_BYTE: begin
        ext_data      = {BITS_SIZE{i_mem_data[7] & ~i_load_unsigned}};
        ext_data[7:0] = i_mem_data[7:0];
      end
      EXT_HALF: begin
        ext_data       = {BITS_SIZE{i_mem_data[15] & ~i_load_unsigned}};
        ext_data[15:0] = i_mem_data[15:0];
      end
      default: ext_data = i_mem_data;
    endcase
  end

  always_comb begin
    if (i_link)
      wb_value = i_pc_link;
    else if (i_mem_to_reg)
      wb_value = ext_data;
    else
      wb_value = i_alu_result;
  end

`ifdef MEM_WB_HALT_DETECT_EN
  logic halt_q, halt_d;
  assign halted = halt_q;
  assign o_halt = halt_q;
`else
  assign halted = 1'b0;
  assign o_halt = 1'b0;
  logic unused_halt;
  assign unused_halt = i_halt;
`endif

  always_comb begin
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    retired_d      = retired_q;
`ifdef MEM_WB_HALT_DETECT_EN
    halt_d         = halt_q;
`endif
    if (!halted && i_step) begin
      if (i_flush) begin
        wb_data_d      = '0;
        wb_rd_d        = '0;
        wb_reg_write_d = 1'b0;
      end else begin
        wb_data_d      = wb_value;
        wb_rd_d        = i_rd;
        // Writes to r0 and from empty slots never reach the register file.
        wb_reg_write_d = i_reg_write & i_valid & (i_rd != '0);
        if (i_valid)
          retired_d = retired_q + BITS_SIZE'(1);
`ifdef MEM_WB_HALT_DETECT_EN
        halt_d = i_valid & i_halt;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      retired_q      <= '0;
`ifdef MEM_WB_HALT_DETECT_EN
      halt_q         <= 1'b0;
`endif
    end else begin
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      retired_q      <= retired_d;
`ifdef MEM_WB_HALT_DETECT_EN
      halt_q         <= halt_d;
`endif
    end
  end

  assign o_wb_data       = wb_data_q;
  assign o_wb_rd         = wb_rd_q;
  assign o_wb_reg_write  = wb_reg_write_q;
  assign o_retired_count = retired_q;

endmodule
